// File: rtl/axi_led_board_pkg.sv
// Shared constants and FSM state types for the LED board AXI4-Lite register slice.
package axi_led_board_pkg;

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam int         ADDR_LSB  = 2;
    localparam int         NUM_REGS  = 4;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_DATA0 = 2'd1;
    localparam logic [1:0] REG_DATA1 = 2'd2;
    localparam logic [1:0] REG_DATA2 = 2'd3;

    typedef enum logic [1:0] {
        WR_EMPTY,
        WR_ADDR,
        WR_DATA,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_VALID
    } rd_state_t;

endpackage

// File: rtl/axi_led_board_s_axi_regs_if.sv
// AXI4-Lite bus bundle between the example-design master BFM and the LED register slave.
interface axi_led_board_s_axi_regs_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

endinterface

// File: rtl/axi_led_board_reg_bank.sv
// Four 32-bit LED registers: byte-strobed write port, combinational read port, packed LED view.
module axi_led_board_reg_bank
    import axi_led_board_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [1:0]               wr_idx,
    input  logic [31:0]              wr_data,
    input  logic [3:0]               wr_strb,
    input  logic [1:0]               rd_idx,
    output logic [31:0]              rd_data,
    output logic [NUM_REGS*32-1:0]   led_regs
);

    logic [31:0] regs [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                    regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read sees the pre-edge contents, so a same-edge write is not visible to the read.
    assign rd_data  = regs[rd_idx];
    assign led_regs = {regs[REG_DATA2], regs[REG_DATA1], regs[REG_DATA0], regs[REG_CTRL]};

endmodule

// File: rtl/axi_led_board_s_axi_regs.sv
// AXI4-Lite slave for the LED board: independent AW/W acceptance, single outstanding write,
// single outstanding read, always-OKAY responses.
//
// write state | meaning
// WR_EMPTY    | no address or data held; AW and W both ready
// WR_ADDR     | address held, waiting for write data
// WR_DATA     | data held, waiting for write address
// WR_RESP     | write committed, BVALID high until BREADY
//
// read state  | meaning
// RD_IDLE     | ARREADY high, waiting for an address
// RD_VALID    | RDATA/RVALID held until RREADY
module axi_led_board_s_axi_regs
    import axi_led_board_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    axi_led_board_s_axi_regs_if.slave         s_axi,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   led_regs,
    output logic                              reg_wr_pulse,
    output logic [1:0]                        reg_wr_idx
);

    wr_state_t                       wr_state;
    rd_state_t                       rd_state;
    logic [1:0]                      aw_idx_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   w_data_q;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] w_strb_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   bank_rd_data;
    logic [C_S_AXI_DATA_WIDTH-1:0]   cm_data;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] cm_strb;
    logic [1:0]                      aw_idx_in;
    logic [1:0]                      ar_idx_in;
    logic [1:0]                      cm_idx;
    logic                            aw_hs;
    logic                            w_hs;
    logic                            ar_hs;
    logic                            wr_commit;
    logic                            unused_bits;

    assign aw_idx_in = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign ar_idx_in = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           s_axi.S_AXI_AWADDR[ADDR_LSB-1:0], s_axi.S_AXI_ARADDR[ADDR_LSB-1:0]};

    // Readies are forced low while reset is asserted, not just after the first edge.
    assign s_axi.S_AXI_AWREADY = !S_AXI_ARESET && (wr_state == WR_EMPTY || wr_state == WR_DATA);
    assign s_axi.S_AXI_WREADY  = !S_AXI_ARESET && (wr_state == WR_EMPTY || wr_state == WR_ADDR);
    assign s_axi.S_AXI_BVALID  = (wr_state == WR_RESP);
    assign s_axi.S_AXI_BRESP   = RESP_OKAY;
    assign s_axi.S_AXI_ARREADY = !S_AXI_ARESET && (rd_state == RD_IDLE);
    assign s_axi.S_AXI_RVALID  = (rd_state == RD_VALID);
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = RESP_OKAY;

    assign aw_hs = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
    assign w_hs  = s_axi.S_AXI_WVALID  && s_axi.S_AXI_WREADY;
    assign ar_hs = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;

    always_comb begin
        wr_commit = 1'b0;
        case (wr_state)
            WR_EMPTY: wr_commit = aw_hs && w_hs;
            WR_ADDR:  wr_commit = w_hs;
            WR_DATA:  wr_commit = aw_hs;
            default:  wr_commit = 1'b0;
        endcase
    end

    assign cm_idx  = (wr_state == WR_ADDR) ? aw_idx_q : aw_idx_in;
    assign cm_data = (wr_state == WR_DATA) ? w_data_q : s_axi.S_AXI_WDATA;
    assign cm_strb = (wr_state == WR_DATA) ? w_strb_q : s_axi.S_AXI_WSTRB;

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            wr_state     <= WR_EMPTY;
            aw_idx_q     <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            reg_wr_pulse <= 1'b0;
            reg_wr_idx   <= '0;
        end else begin
            reg_wr_pulse <= wr_commit;
            if (wr_commit) begin
                reg_wr_idx <= cm_idx;
            end
            case (wr_state)
                WR_EMPTY: begin
                    if (wr_commit) begin
                        wr_state <= WR_RESP;
                    end else if (aw_hs) begin
                        aw_idx_q <= aw_idx_in;
                        wr_state <= WR_ADDR;
                    end else if (w_hs) begin
                        w_data_q <= s_axi.S_AXI_WDATA;
                        w_strb_q <= s_axi.S_AXI_WSTRB;
                        wr_state <= WR_DATA;
                    end
                end
                WR_ADDR, WR_DATA: begin
                    if (wr_commit) begin
                        wr_state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        wr_state <= WR_EMPTY;
                    end
                end
                default: wr_state <= WR_EMPTY;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rd_state <= RD_IDLE;
            rdata_q  <= '0;
        end else if (rd_state == RD_IDLE) begin
            if (ar_hs) begin
                rdata_q  <= bank_rd_data;
                rd_state <= RD_VALID;
            end
        end else if (s_axi.S_AXI_RREADY) begin
            rd_state <= RD_IDLE;
        end
    end

    axi_led_board_reg_bank u_reg_bank (
        .clk      (S_AXI_ACLK),
        .rst      (S_AXI_ARESET),
        .wr_en    (wr_commit),
        .wr_idx   (cm_idx),
        .wr_data  (cm_data),
        .wr_strb  (cm_strb),
        .rd_idx   (ar_idx_in),
        .rd_data  (bank_rd_data),
        .led_regs (led_regs)
    );

endmodule

// File: tb/tb_axi_led_board_s_axi_regs.sv
// Bench for the LED board AXI4-Lite register slave: directed plan plus randomized traffic,
// checked against a transaction-level register model.
module tb_axi_led_board_s_axi_regs;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  s;
    } wbeat_t;

    logic         tb_ACLK = 1'b0;
    logic         tb_ARESET;
    logic [127:0] led_regs;
    logic         reg_wr_pulse;
    logic [1:0]   reg_wr_idx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] mdl [4];
    logic [1:0]  aw_q [$];
    wbeat_t      w_q  [$];
    logic [31:0] rd_q [$];
    int          aw_edge = 0;
    int          w_edge = 0;
    int          last_b_edge = 0;
    int          bv_cnt = 0;
    int          rv_cnt = 0;
    logic        prev_bv = 1'b0;
    logic        prev_rv = 1'b0;
    logic        prev_rready = 1'b0;
    logic [31:0] prev_rdata = '0;
    logic        b_rise;
    logic [1:0]  m_idx;
    wbeat_t      m_beat;
    logic [31:0] rd;

    always #5 tb_ACLK = ~tb_ACLK;
    always @(posedge tb_ACLK) cyc <= cyc + 1;

    axi_led_board_s_axi_regs_if bus ();

    axi_led_board_s_axi_regs dut (
        .S_AXI_ACLK   (tb_ACLK),
        .S_AXI_ARESET (tb_ARESET),
        .s_axi        (bus),
        .led_regs     (led_regs),
        .reg_wr_pulse (reg_wr_pulse),
        .reg_wr_idx   (reg_wr_idx)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: no response within 200 cycles, expected one", nm);
    endtask

    // Model: every cycle out of reset, compare DUT outputs with what the register rules demand.
    always @(negedge tb_ACLK) begin
        if (tb_ARESET) begin
            for (int i = 0; i < 4; i++) mdl[i] = '0;
            aw_q.delete();
            w_q.delete();
            rd_q.delete();
            prev_bv = 1'b0;
            prev_rv = 1'b0;
            prev_rready = 1'b0;
        end else begin
            b_rise = bus.S_AXI_BVALID && !prev_bv;
            chk("wr_pulse_vs_bvalid_rise", reg_wr_pulse, b_rise);
            if (reg_wr_pulse) begin
                if (aw_q.size() == 0 || w_q.size() == 0) begin
                    tmo("wr_pulse_without_aw_and_w");
                end else begin
                    m_idx  = aw_q.pop_front();
                    m_beat = w_q.pop_front();
                    for (int b = 0; b < 4; b++)
                        if (m_beat.s[b]) mdl[m_idx][8*b +: 8] = m_beat.d[8*b +: 8];
                    chk("wr_idx", reg_wr_idx, m_idx);
                    chk("wr_commit_edge", cyc, (aw_edge > w_edge) ? aw_edge : w_edge);
                    last_b_edge = cyc;
                end
            end
            chk("led_regs", led_regs, {mdl[3], mdl[2], mdl[1], mdl[0]});
            if (bus.S_AXI_BVALID) begin
                bv_cnt = b_rise ? 1 : bv_cnt + 1;
                chk("bresp", bus.S_AXI_BRESP, 2'b00);
                chk("awready_during_b", bus.S_AXI_AWREADY, 1'b0);
                chk("wready_during_b", bus.S_AXI_WREADY, 1'b0);
            end
            if (bus.S_AXI_RVALID) begin
                rv_cnt = prev_rv ? rv_cnt + 1 : 1;
                chk("arready_during_r", bus.S_AXI_ARREADY, 1'b0);
                chk("rresp", bus.S_AXI_RRESP, 2'b00);
                if (prev_rv && !prev_rready) chk("rdata_stable", bus.S_AXI_RDATA, prev_rdata);
                if (bus.S_AXI_RREADY) begin
                    if (rd_q.size() == 0) tmo("rdata_without_ar");
                    else chk("rdata", bus.S_AXI_RDATA, rd_q.pop_front());
                end
            end
            if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY) begin
                aw_q.push_back(bus.S_AXI_AWADDR[3:2]);
                aw_edge = cyc + 1;
            end
            if (bus.S_AXI_WVALID && bus.S_AXI_WREADY) begin
                w_q.push_back({bus.S_AXI_WDATA, bus.S_AXI_WSTRB});
                w_edge = cyc + 1;
            end
            if (bus.S_AXI_ARVALID && bus.S_AXI_ARREADY)
                rd_q.push_back(mdl[bus.S_AXI_ARADDR[3:2]]);
            prev_bv     = bus.S_AXI_BVALID;
            prev_rv     = bus.S_AXI_RVALID;
            prev_rready = bus.S_AXI_RREADY;
            prev_rdata  = bus.S_AXI_RDATA;
        end
    end

    task automatic drive_aw(input logic [3:0] a, input int dly);
        int n;
        n = 0;
        repeat (dly) @(posedge tb_ACLK);
        #1;
        bus.S_AXI_AWADDR  = a;
        bus.S_AXI_AWPROT  = 3'($urandom);
        bus.S_AXI_AWVALID = 1'b1;
        @(negedge tb_ACLK);
        while (!bus.S_AXI_AWREADY && n < 200) begin @(negedge tb_ACLK); n++; end
        if (n >= 200) tmo("aw_handshake");
        @(posedge tb_ACLK); #1;
        bus.S_AXI_AWVALID = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        int n;
        n = 0;
        repeat (dly) @(posedge tb_ACLK);
        #1;
        bus.S_AXI_WDATA  = d;
        bus.S_AXI_WSTRB  = s;
        bus.S_AXI_WVALID = 1'b1;
        @(negedge tb_ACLK);
        while (!bus.S_AXI_WREADY && n < 200) begin @(negedge tb_ACLK); n++; end
        if (n >= 200) tmo("w_handshake");
        @(posedge tb_ACLK); #1;
        bus.S_AXI_WVALID = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly);
        int n;
        n = 0;
        fork
            drive_aw(a, aw_dly);
            drive_w(d, s, w_dly);
        join
        while (!bus.S_AXI_BVALID && n < 200) begin @(negedge tb_ACLK); n++; end
        if (n >= 200) tmo("bvalid_wait");
        repeat (b_dly) @(posedge tb_ACLK);
        #1;
        bus.S_AXI_BREADY = 1'b1;
        @(posedge tb_ACLK); #1;
        bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a, input int ar_dly, input int r_dly,
                           output logic [31:0] d);
        int n;
        n = 0;
        repeat (ar_dly) @(posedge tb_ACLK);
        #1;
        bus.S_AXI_ARADDR  = a;
        bus.S_AXI_ARPROT  = 3'($urandom);
        bus.S_AXI_ARVALID = 1'b1;
        @(negedge tb_ACLK);
        while (!bus.S_AXI_ARREADY && n < 200) begin @(negedge tb_ACLK); n++; end
        if (n >= 200) tmo("ar_handshake");
        @(posedge tb_ACLK); #1;
        bus.S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!bus.S_AXI_RVALID && n < 200) begin @(negedge tb_ACLK); n++; end
        if (n >= 200) tmo("rvalid_wait");
        repeat (r_dly) @(posedge tb_ACLK);
        #1;
        bus.S_AXI_RREADY = 1'b1;
        d = bus.S_AXI_RDATA;
        @(posedge tb_ACLK); #1;
        bus.S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        logic [31:0] vec [4];
        logic [31:0] rd2;
        vec[0] = 32'h0101FFFF; vec[1] = 32'habcd0001; vec[2] = 32'hdead0011; vec[3] = 32'hbeef0011;

        tb_ARESET = 1'b1;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        #2;
        chk("rst_awready", bus.S_AXI_AWREADY, 1'b0);
        chk("rst_wready", bus.S_AXI_WREADY, 1'b0);
        chk("rst_arready", bus.S_AXI_ARREADY, 1'b0);
        chk("rst_bvalid", bus.S_AXI_BVALID, 1'b0);
        chk("rst_rvalid", bus.S_AXI_RVALID, 1'b0);
        chk("rst_outputs", {reg_wr_pulse, reg_wr_idx, bus.S_AXI_RDATA}, '0);
        chk("rst_led_regs", led_regs, '0);
        repeat (3) @(posedge tb_ACLK);
        @(negedge tb_ACLK); #1;
        tb_ARESET = 1'b0;
        @(posedge tb_ACLK); #1;

        // Write then readback with the BFM vectors.
        for (int i = 0; i < 4; i++) do_write(4'(i * 4), vec[i], 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            do_read(4'(i * 4), 0, 0, rd);
            chk("bfm_readback", rd, vec[i]);
        end
        chk("bfm_led_regs", led_regs, 128'hbeef0011_dead0011_abcd0001_0101FFFF);

        // Channel ordering.
        do_write(4'h4, 32'h12345678, 4'hF, 3, 0, 0);
        chk("wfirst_gap", aw_edge - w_edge, 3);
        chk("wfirst_b_after_aw", last_b_edge, aw_edge);
        do_read(4'h4, 0, 0, rd);
        chk("wfirst_reg1", rd, 32'h12345678);
        do_write(4'h4, 32'h0, 4'hF, 0, 0, 0);
        do_write(4'h4, 32'h12345678, 4'hF, 0, 3, 0);
        chk("awfirst_gap", w_edge - aw_edge, 3);
        chk("awfirst_b_after_w", last_b_edge, w_edge);
        do_read(4'h4, 0, 0, rd);
        chk("awfirst_reg1", rd, 32'h12345678);

        // Byte strobes.
        do_write(4'h8, 32'hdead0011, 4'hF, 0, 0, 0);
        do_write(4'h8, 32'hFFFFFFFF, 4'b0101, 0, 0, 0);
        do_read(4'h8, 0, 0, rd);
        chk("strobe_reg2", rd, 32'hdeFF00FF);

        // Backpressure on B and R.
        do_write(4'hC, 32'h5a5a0f0f, 4'hF, 0, 0, 5);
        chk("b_backpressure_cycles", bv_cnt, 6);
        do_read(4'hC, 0, 5, rd);
        chk("r_backpressure_cycles", rv_cnt, 6);
        chk("r_backpressure_data", rd, 32'h5a5a0f0f);

        // Same-edge write commit and read to reg0.
        do_write(4'h0, 32'h0, 4'hF, 0, 0, 0);
        fork
            do_write(4'h0, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
            do_read(4'h0, 0, 0, rd);
        join
        chk("collision_pre_write", rd, 32'h00000000);
        do_read(4'h1, 0, 0, rd);
        chk("collision_after", rd, 32'hA5A5A5A5);

        // Randomized traffic.
        for (int it = 0; it < 150; it++) begin
            int op;
            op = int'($urandom_range(0, 2));
            if (op == 0) begin
                do_write(4'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end else if (op == 1) begin
                do_read(4'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rd);
            end else begin
                fork
                    do_write(4'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
                    do_read(4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rd2);
                join
            end
        end

        // Reset while a write response and a read response are both pending.
        bus.S_AXI_AWADDR = 4'h4; bus.S_AXI_WDATA = 32'hcafef00d; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_ARADDR = 4'h8;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
        @(posedge tb_ACLK); #1;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        chk("pre_rst_bvalid", bus.S_AXI_BVALID, 1'b1);
        chk("pre_rst_rvalid", bus.S_AXI_RVALID, 1'b1);
        @(negedge tb_ACLK); #1;
        tb_ARESET = 1'b1;
        #1;
        chk("async_rst_bvalid", bus.S_AXI_BVALID, 1'b0);
        chk("async_rst_rvalid", bus.S_AXI_RVALID, 1'b0);
        chk("async_rst_led_regs", led_regs, '0);
        repeat (2) @(posedge tb_ACLK);
        @(negedge tb_ACLK); #1;
        tb_ARESET = 1'b0;
        repeat (3) begin
            @(negedge tb_ACLK);
            chk("no_b_after_rst", bus.S_AXI_BVALID, 1'b0);
        end
        @(posedge tb_ACLK); #1;
        for (int i = 0; i < 4; i++) begin
            do_read(4'(i * 4), 0, 0, rd);
            chk("post_rst_readback", rd, 32'h0);
        end

        repeat (3) @(posedge tb_ACLK);
        chk("pending_aw_left", aw_q.size(), 0);
        chk("pending_w_left", w_q.size(), 0);
        chk("pending_rd_left", rd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
